// File: rtl/clken_gen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package clken_gen_pkg;

    localparam int unsigned W_DEF   = 16;
    localparam int unsigned NCH_MAX = 8;

    typedef enum logic {
        WAIT = 1'b0,
        RUN  = 1'b1
    } lock_state_t;

    // Lock counter width: clog2(lock_cyc+1), never narrower than one bit.
    function automatic int unsigned lock_cnt_w(input int unsigned lock_cyc);
        int unsigned w;
        w = $clog2(lock_cyc + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/clken_chan.sv
// One fractional clock-enable channel: shadow ratio, accumulator, pulse output.
// Optional CLKEN_GEN_SQ_EN adds a toggle output giving a num/(2*den) square wave.
module clken_chan
    import clken_gen_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic         run,
    input  logic [W-1:0] num_in,
    input  logic [W-1:0] den_in,
    output logic         ce,
    output logic         cfg_err
`ifdef CLKEN_GEN_SQ_EN
    ,
    output logic         sq
`endif
);

    logic [W-1:0] num_sh;
    logic [W-1:0] den_sh;
    logic [W:0]   acc;
    logic [W:0]   sum_c;
    logic [W:0]   den_ext_c;

    // acc < den and num <= den, so the W+1-bit sum cannot overflow.
    always_comb begin
        sum_c     = acc + {1'b0, num_sh};
        den_ext_c = {1'b0, den_sh};
    end

    // Shadow capture, phase clear and accumulate; load has priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_sh  <= '0;
            den_sh  <= W'(1);
            acc     <= '0;
            ce      <= 1'b0;
            cfg_err <= 1'b0;
`ifdef CLKEN_GEN_SQ_EN
            sq      <= 1'b0;
`endif
        end else if (load) begin
            num_sh  <= num_in;
            den_sh  <= den_in;
            cfg_err <= (den_in == '0) || (num_in > den_in);
            acc     <= '0;
            ce      <= 1'b0;
`ifdef CLKEN_GEN_SQ_EN
            sq      <= 1'b0;
`endif
        end else if (clr) begin
            acc     <= '0;
            ce      <= 1'b0;
`ifdef CLKEN_GEN_SQ_EN
            sq      <= 1'b0;
`endif
        end else begin
`ifdef CLKEN_GEN_SQ_EN
            sq      <= sq ^ ce;
`endif
            if (run && !cfg_err) begin
                if (sum_c >= den_ext_c) begin
                    acc <= sum_c - den_ext_c;
                    ce  <= 1'b1;
                end else begin
                    acc <= sum_c;
                    ce  <= 1'b0;
                end
            end else begin
                ce <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator with lock sequencing and
// common phase resync. Optional macro CLKEN_GEN_SQ_EN adds the sq outputs.
module clken_gen
    import clken_gen_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned W        = W_DEF,
    parameter int unsigned LOCK_CYC = 1024
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic [NCH*W-1:0] num,
    input  logic [NCH*W-1:0] den,
    input  logic             load,
    input  logic             resync,
    output logic [NCH-1:0]   ce,
    output logic             locked,
    output logic [NCH-1:0]   cfg_err
`ifdef CLKEN_GEN_SQ_EN
    ,
    output logic [NCH-1:0]   sq
`endif
);

    localparam int unsigned CW = lock_cnt_w(LOCK_CYC);

    lock_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          fresh;
    logic          clr_c;

    // Resync only acts while running; load overrides it inside each channel.
    always_comb begin
        clr_c = resync && (state == RUN);
    end

    // Lock sequencing; the cycle right after a load is not counted so the
    // freshly captured shadow config settles before the count starts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (load) begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
        end else if (state == WAIT) begin
            if (!(fresh && (LOCK_CYC != 0))) begin
                if ((32'(cnt) + 32'd1) >= LOCK_CYC) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
        end
    end

    // Lock state register and registered locked output.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state  <= WAIT;
            cnt    <= '0;
            fresh  <= 1'b0;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            fresh  <= load;
            locked <= (state_nxt == RUN);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clken_chan #(
            .W(W)
        ) u_chan (
            .clk    (refclk),
            .rst    (rst),
            .load   (load),
            .clr    (clr_c),
            .run    (locked),
            .num_in (num[i*W +: W]),
            .den_in (den[i*W +: W]),
            .ce     (ce[i]),
            .cfg_err(cfg_err[i])
`ifdef CLKEN_GEN_SQ_EN
            ,
            .sq     (sq[i])
`endif
        );
    end

endmodule

// File: tb/tb_clken_gen.sv
// Directed, table-driven bench for clken_gen (NCH=2, W=16, LOCK_CYC=8).
module tb_clken_gen;

    localparam int unsigned NCH      = 2;
    localparam int unsigned W        = 16;
    localparam int unsigned LOCK_CYC = 8;

    logic             refclk = 1'b0;
    logic             rst;
    logic [NCH*W-1:0] num;
    logic [NCH*W-1:0] den;
    logic             load;
    logic             resync;
    logic [NCH-1:0]   ce;
    logic             locked;
    logic [NCH-1:0]   cfg_err;
`ifdef CLKEN_GEN_SQ_EN
    logic [NCH-1:0]   sq;
`endif

    clken_gen #(
        .NCH     (NCH),
        .W       (W),
        .LOCK_CYC(LOCK_CYC)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .num    (num),
        .den    (den),
        .load   (load),
        .resync (resync),
        .ce     (ce),
        .locked (locked),
        .cfg_err(cfg_err)
`ifdef CLKEN_GEN_SQ_EN
        ,
        .sq     (sq)
`endif
    );

    always #5 refclk = ~refclk;

    typedef struct {
        int       n0;
        int       d0;
        int       n1;
        int       d1;
        logic [1:0] err;
        int       cnt0;
        int       cnt1;
    } vec_t;

    vec_t vt[5];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // Closed-form pulse model: the k-th accumulate fires when floor(k*n/d) steps.
    function automatic int exp_ce(input int n, input int d, input int k);
        if (d == 0 || n > d) return 0;
        return (k * n) / d - ((k - 1) * n) / d;
    endfunction

    task automatic load_cfg(input vec_t v, input logic rs);
        num    = {W'(v.n1), W'(v.n0)};
        den    = {W'(v.d1), W'(v.d0)};
        load   = 1'b1;
        resync = rs;
        step();
        load   = 1'b0;
        resync = 1'b0;
        check("load_locked_drop", 32'(locked), 32'd0);
        check("load_ce_clear", 32'(ce), 32'd0);
        check("load_cfg_err", 32'(cfg_err), 32'(v.err));
        repeat (LOCK_CYC) step();
        check("lock_early", 32'(locked), 32'd0);
        step();
        check("lock_rise", 32'(locked), 32'd1);
    endtask

    task automatic run_check(input vec_t v, input int ncyc, input string tag,
                             output int c0, output int c1);
        logic [1:0] e;
        c0 = 0;
        c1 = 0;
        for (int k = 1; k <= ncyc; k++) begin
            step();
            e = {1'(exp_ce(v.n1, v.d1, k)), 1'(exp_ce(v.n0, v.d0, k))};
            check($sformatf("%s_ce_k%0d", tag, k), 32'(ce), 32'(e));
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
        end
        check($sformatf("%s_locked_hold", tag), 32'(locked), 32'd1);
    endtask

    task automatic relock_after_reset(input string tag);
        for (int e = 1; e <= int'(LOCK_CYC); e++) begin
            step();
            if (e == int'(LOCK_CYC) - 1)
                check($sformatf("%s_lock_early", tag), 32'(locked), 32'd0);
            if (e == int'(LOCK_CYC))
                check($sformatf("%s_lock_rise", tag), 32'(locked), 32'd1);
        end
        repeat (3) step();
        check($sformatf("%s_idle_ce", tag), 32'(ce), 32'd0);
    endtask

    initial begin
        vec_t lr;
        vec_t sqv;
        vec_t rv;
        int   c0;
        int   c1;

        vt[0] = '{n0: 2, d0: 5, n1: 1, d1: 10, err: 2'b00, cnt0: 40,  cnt1: 10};
        vt[1] = '{n0: 7, d0: 7, n1: 0, d1: 3,  err: 2'b00, cnt0: 100, cnt1: 0};
        vt[2] = '{n0: 2, d0: 5, n1: 3, d1: 0,  err: 2'b10, cnt0: 40,  cnt1: 0};
        vt[3] = '{n0: 2, d0: 5, n1: 5, d1: 3,  err: 2'b10, cnt0: 40,  cnt1: 0};
        vt[4] = '{n0: 3, d0: 7, n1: 2, d1: 7,  err: 2'b00, cnt0: 42,  cnt1: 28};
        lr    = '{n0: 1, d0: 2, n1: 1, d1: 4,  err: 2'b00, cnt0: 0,   cnt1: 0};
        sqv   = '{n0: 1, d0: 2, n1: 1, d1: 2,  err: 2'b00, cnt0: 0,   cnt1: 0};
        rv    = '{n0: 7, d0: 7, n1: 5, d1: 3,  err: 2'b10, cnt0: 0,   cnt1: 0};

        rst    = 1'b1;
        load   = 1'b0;
        resync = 1'b0;
        num    = '0;
        den    = '0;
        repeat (3) step();
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
`ifdef CLKEN_GEN_SQ_EN
        check("rst_sq", 32'(sq), 32'd0);
`endif
        rst = 1'b0;
        relock_after_reset("por");

        for (int i = 0; i < 5; i++) begin
            load_cfg(vt[i], 1'b0);
            run_check(vt[i], 100, $sformatf("v%0d", i), c0, c1);
            check($sformatf("v%0d_count0", i), 32'(c0), 32'(vt[i].cnt0));
            check($sformatf("v%0d_count1", i), 32'(c1), 32'(vt[i].cnt1));
        end

        // Resync mid-run (3/7, 2/7): both channels restart from acc=0 in phase.
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_ce_low", 32'(ce), 32'd0);
        check("resync_locked", 32'(locked), 32'd1);
        run_check(vt[4], 30, "post_resync", c0, c1);

        // Load and resync together: load wins and restarts the lock sequence.
        load_cfg(lr, 1'b1);
        run_check(lr, 20, "load_resync", c0, c1);

`ifdef CLKEN_GEN_SQ_EN
        // 1/2 ratio: ce every other cycle, sq toggles after each pulse.
        load_cfg(sqv, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("sq_k%0d", k), 32'(sq[0]), 32'(((k - 1) / 2) % 2));
        end
`else
        sqv.n0 = sqv.n0;
`endif

        // Asynchronous reset mid-run with ce and cfg_err both non-zero.
        load_cfg(rv, 1'b0);
        run_check(rv, 5, "pre_rst", c0, c1);
        check("pre_rst_cfg_err", 32'(cfg_err), 32'h2);
        @(posedge refclk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_ce", 32'(ce), 32'd0);
        check("async_rst_locked", 32'(locked), 32'd0);
        check("async_rst_cfg_err", 32'(cfg_err), 32'd0);
        step();
        rst = 1'b0;
        relock_after_reset("relock");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
